data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Data-side memory and peripheral controller that sits directly downstream of the CPU's MEM stage. It consumes the stage's address, store data, op size and write enable, and returns load data in the same cycle. It contains a byte-lane word RAM plus a small memory-mapped block: a GPIO output register, a 64-bit cycle timer with compare/interrupt, and a status register with a sticky misalignment flag.

## Interface
- DEPTH_WORDS, 1024: RAM depth in 32-bit words; power of two, at least 4.
- MMIO_BASE, 32'h1000_0000: base address of the peripheral register window.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- mem_addr_i  input  32  byte address from the MEM stage.
- mem_st_data_i  input  32  store data, right-justified (rs2 value).
- mem_op_size_i  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- mem_wr_en_i  input  1  store strobe for the current cycle.
- mem_rd_data_o  output  32  load data, right-justified and zero-extended; sign extension is done by the MEM stage.
- gpio_o  output  32  GPIO output register.
- timer_irq_o  output  1  timer interrupt level.
- misalign_o  output  1  sticky misaligned-access flag.

## Operation
- Address decode:
  - RAM hit when mem_addr_i < DEPTH_WORDS*4; word index is mem_addr_i[log2(DEPTH_WORDS)+1:2].
  - MMIO hit when mem_addr_i[31:5] == MMIO_BASE[31:5].
  - Any other address is unmapped: loads return 0, stores are ignored, no flag is set.
- Misalignment: a half access with addr[0]=1, or a word or reserved access with addr[1:0]≠0.
  - Any misaligned access to a mapped address (load or store) sets the misalignment flag at the next edge.
  - Misaligned stores are dropped; misaligned loads return 0.
- RAM store:
  - Byte: mem_st_data_i[7:0] is written to lane addr[1:0].
  - Half: mem_st_data_i[15:0] is written to lanes {addr[1],0} and {addr[1],1}.
  - Word: all four lanes are written.
  - Lanes not addressed keep their value.
- RAM load: the addressed byte or half is shifted down to bit 0 and zero-extended; a word load returns the full word.
- MMIO registers (offset from MMIO_BASE; word accesses only):
  - A non-word MMIO access counts as misaligned.
  - Undefined offsets read 0 and ignore writes.
  - 0x00 GPIO: read/write.
  - 0x04 MTIME_LO, 0x08 MTIME_HI: read/write halves of the 64-bit counter.
  - 0x0C MTIMECMP_LO, 0x10 MTIMECMP_HI: read/write halves of the 64-bit compare value.
  - 0x14 STATUS: bit0 = misalign flag, bit1 = timer_irq_o, other bits read 0. Writing 1 to bit0 clears the flag; writes to bit1 are ignored.
- Timer:
  - mtime increments by 1 every cycle and wraps from 2^64-1 to 0.
  - A write to either half of mtime replaces that half with the written value and suppresses the increment in that cycle; the other half is held.
  - timer_irq_o = (mtime >= mtimecmp), unsigned 64-bit compare, combinational from the registers only.
- Reset values:
  - gpio_o = 0; mtime = 0; mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF; timer_irq_o = 0; misalign_o = 0.
  - RAM contents are not reset.

## Timing
- Loads are combinational: mem_rd_data_o is valid in the same cycle as mem_addr_i, with no pipeline delay.
- Stores and register writes commit at the rising edge ending the cycle in which mem_wr_en_i=1.
- A load of the location being written in the same cycle returns the old value; the new value is visible from the next cycle.
- An mtime read returns the value held in the current cycle, before the increment at the edge.
- timer_irq_o tracks the registers, so it reflects a mtime/mtimecmp write one cycle after that write.
- Flag set vs. clear in the same cycle: a write-1-to-clear of STATUS.bit0 together with a new misaligned access leaves the flag set (set wins). Because MMIO stores must be word-aligned, the two conditions cannot come from one access.
- Reset asserted mid-operation: the reset values above take effect at that edge. Any store presented in the same cycle as rst_i=1 is dropped, RAM writes included.

## Test plan
- Sub-word stores:
  - Word store 0x1122_3344 at 0x10, then byte store 0xAA at 0x11 → word load at 0x10 returns 0x1122_AA44.
  - Byte load at 0x13 returns 0x0000_0011.
  - Half load at 0x12 returns 0x0000_1122.
- Same-cycle read of the store target: store 0xDEAD_BEEF at 0x20 while loading 0x20 → the load returns the old data in that cycle and 0xDEAD_BEEF in the next cycle.
- Misaligned and unmapped accesses:
  - Word store at 0x22 → RAM word at 0x20 is unchanged, misalign_o=1 from the next cycle.
  - Writing STATUS=1 clears misalign_o.
  - Store to 0x2000_0000 → misalign_o stays 0 and the load from that address returns 0.
- Timer interrupt:
  - Write MTIMECMP_HI=0, then MTIMECMP_LO=100 → timer_irq_o rises in the first cycle in which mtime reads ≥ 100.
  - Writing MTIME_LO=0 drops timer_irq_o in the next cycle.
- Timer wrap: write MTIME_HI=0xFFFF_FFFF and MTIME_LO=0xFFFF_FFFE → after 2 cycles, both halves read 0.
- Reset: reset mid-run with gpio=0x5A → gpio_o=0, mtime=0, timer_irq_o=0, misalign_o=0 on the cycle after the reset edge, and RAM data is preserved.

Source files
------------

// File: rtl/data_mem_ctrl_if.sv
// Data-side bus between the CPU MEM stage (master) and data_mem_ctrl (slave).
// Loads return on mem_rd_data in the same cycle the address is presented.
interface data_mem_ctrl_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_st_data;
  logic [1:0]  mem_op_size;
  logic        mem_wr_en;
  logic [31:0] mem_rd_data;

  modport master (
    output mem_addr,
    output mem_st_data,
    output mem_op_size,
    output mem_wr_en,
    input  mem_rd_data
  );

  modport slave (
    input  mem_addr,
    input  mem_st_data,
    input  mem_op_size,
    input  mem_wr_en,
    output mem_rd_data
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data memory and peripheral controller: byte-lane word RAM, GPIO register,
// 64-bit cycle timer with compare interrupt, and a status register holding a
// sticky misaligned-access flag. Loads are combinational, stores commit at the
// rising edge. Every cycle presents an access, so an idle MEM stage should
// drive an aligned address to avoid flagging misalignment.
module data_mem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  data_mem_ctrl_if.slave       bus,
  output logic [31:0]          gpio_o,
  output logic                 timer_irq_o,
  output logic                 misalign_o
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  // MMIO register word offsets (addr[4:2])
  localparam logic [2:0] REG_GPIO   = 3'd0;
  localparam logic [2:0] REG_MT_LO  = 3'd1;
  localparam logic [2:0] REG_MT_HI  = 3'd2;
  localparam logic [2:0] REG_CMP_LO = 3'd3;
  localparam logic [2:0] REG_CMP_HI = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;

  // Bus aliases
  logic [31:0] addr_s;
  logic [31:0] st_data_s;
  logic [1:0]  op_size_s;
  logic        wr_en_s;

  assign addr_s    = bus.mem_addr;
  assign st_data_s = bus.mem_st_data;
  assign op_size_s = bus.mem_op_size;
  assign wr_en_s   = bus.mem_wr_en;

  // State
  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] gpio_q,     gpio_d;
  logic [63:0] mtime_q,    mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        misalign_q, misalign_d;

  // Decode / datapath
  logic          ram_hit_s;
  logic          mmio_hit_s;
  logic          size_word_s;
  logic          misalign_s;
  logic          mis_acc_s;
  logic          ram_we_s;
  logic          mmio_wr_s;
  logic          status_clr_s;
  logic [3:0]    be_s;
  logic [31:0]   wdata_s;
  logic [AW-1:0] ram_idx_s;
  logic [31:0]   ram_word_s;
  logic [31:0]   ram_shift_s;
  logic [31:0]   ram_rd_s;
  logic [31:0]   mmio_rd_s;
  logic [31:0]   rd_data_s;
  logic          irq_s;

  assign ram_idx_s  = addr_s[AW+1:2];
  assign ram_word_s = mem_q[ram_idx_s];
  assign irq_s      = (mtime_q >= mtimecmp_q);

  // Address decode and alignment classification of the current access
  always_comb begin
    ram_hit_s   = ({1'b0, addr_s} < RAM_BYTES);
    mmio_hit_s  = 1'b0;
    size_word_s = 1'b0;
    misalign_s  = 1'b0;
    if (ram_hit_s) begin
      mmio_hit_s = 1'b0;
    end else begin
      mmio_hit_s = (addr_s[31:5] == MMIO_BASE[31:5]);
    end
    case (op_size_s)
      SZ_BYTE: begin
        size_word_s = 1'b0;
        misalign_s  = 1'b0;
      end
      SZ_HALF: begin
        size_word_s = 1'b0;
        misalign_s  = addr_s[0];
      end
      default: begin
        size_word_s = 1'b1;
        misalign_s  = (addr_s[1:0] != 2'b00);
      end
    endcase
    // MMIO registers only accept aligned word accesses
    mis_acc_s = (ram_hit_s && misalign_s) ||
                (mmio_hit_s && (misalign_s || !size_word_s));
  end

  // Byte-lane enables and lane-replicated store data for RAM writes
  always_comb begin
    be_s    = 4'b0000;
    wdata_s = st_data_s;
    case (op_size_s)
      SZ_BYTE: begin
        be_s    = 4'b0001 << addr_s[1:0];
        wdata_s = {4{st_data_s[7:0]}};
      end
      SZ_HALF: begin
        if (addr_s[1]) begin
          be_s = 4'b1100;
        end else begin
          be_s = 4'b0011;
        end
        wdata_s = {2{st_data_s[15:0]}};
      end
      default: begin
        be_s    = 4'b1111;
        wdata_s = st_data_s;
      end
    endcase
    ram_we_s = wr_en_s && ram_hit_s && !misalign_s && !rst_i;
  end

  // RAM byte-lane write port; contents are deliberately not reset
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_we_s && be_s[b]) begin
        mem_q[ram_idx_s][8*b +: 8] <= wdata_s[8*b +: 8];
      end
    end
  end

  // RAM load alignment: shift addressed lane(s) to bit 0 and zero-extend
  always_comb begin
    ram_shift_s = ram_word_s >> {addr_s[1:0], 3'b000};
    case (op_size_s)
      SZ_BYTE: ram_rd_s = {24'h00_0000, ram_shift_s[7:0]};
      SZ_HALF: ram_rd_s = {16'h0000, ram_shift_s[15:0]};
      default: ram_rd_s = ram_word_s;
    endcase
  end

  // MMIO read mux
  always_comb begin
    case (addr_s[4:2])
      REG_GPIO:   mmio_rd_s = gpio_q;
      REG_MT_LO:  mmio_rd_s = mtime_q[31:0];
      REG_MT_HI:  mmio_rd_s = mtime_q[63:32];
      REG_CMP_LO: mmio_rd_s = mtimecmp_q[31:0];
      REG_CMP_HI: mmio_rd_s = mtimecmp_q[63:32];
      REG_STATUS: mmio_rd_s = {30'h0000_0000, irq_s, misalign_q};
      default:    mmio_rd_s = 32'h0000_0000;
    endcase
  end

  // Load data select: misaligned and unmapped accesses return zero
  always_comb begin
    rd_data_s = 32'h0000_0000;
    if (mis_acc_s) begin
      rd_data_s = 32'h0000_0000;
    end else if (ram_hit_s) begin
      rd_data_s = ram_rd_s;
    end else if (mmio_hit_s) begin
      rd_data_s = mmio_rd_s;
    end else begin
      rd_data_s = 32'h0000_0000;
    end
  end

  assign bus.mem_rd_data = rd_data_s;

  // Register next-state: MMIO writes, timer increment, sticky flag (set wins)
  always_comb begin
    gpio_d       = gpio_q;
    mtime_d      = mtime_q + 64'd1;
    mtimecmp_d   = mtimecmp_q;
    misalign_d   = misalign_q;
    mmio_wr_s    = wr_en_s && mmio_hit_s && !mis_acc_s;
    status_clr_s = 1'b0;
    if (mmio_wr_s) begin
      case (addr_s[4:2])
        REG_GPIO:   gpio_d = st_data_s;
        REG_MT_LO:  mtime_d = {mtime_q[63:32], st_data_s};
        REG_MT_HI:  mtime_d = {st_data_s, mtime_q[31:0]};
        REG_CMP_LO: mtimecmp_d = {mtimecmp_q[63:32], st_data_s};
        REG_CMP_HI: mtimecmp_d = {st_data_s, mtimecmp_q[31:0]};
        REG_STATUS: status_clr_s = st_data_s[0];
        default:    status_clr_s = 1'b0;
      endcase
    end else begin
      status_clr_s = 1'b0;
    end
    if (mis_acc_s) begin
      misalign_d = 1'b1;
    end else if (status_clr_s) begin
      misalign_d = 1'b0;
    end else begin
      misalign_d = misalign_q;
    end
  end

  // Register state update with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gpio_q     <= 32'h0000_0000;
      mtime_q    <= 64'h0000_0000_0000_0000;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      misalign_q <= 1'b0;
    end else begin
      gpio_q     <= gpio_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      misalign_q <= misalign_d;
    end
  end

  assign gpio_o      = gpio_q;
  assign misalign_o  = misalign_q;
  assign timer_irq_o = irq_s;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: a table of bus vectors plus
// hand-written timer and reset sequences, checked through a scoreboard queue.
module tb_data_mem_ctrl;

  localparam logic [31:0] B  = 32'h1000_0000;
  localparam logic [1:0]  SB = 2'b00;
  localparam logic [1:0]  SH = 2'b01;
  localparam logic [1:0]  SW = 2'b10;

  logic        clk;
  logic        rst;
  logic [31:0] gpio;
  logic        irq;
  logic        mis;

  data_mem_ctrl_if bus ();

  data_mem_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus.slave),
    .gpio_o      (gpio),
    .timer_irq_o (irq),
    .misalign_o  (mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        crd;
    logic [31:0] rd;
    logic        cmis;
    logic        mis;
    logic        cirq;
    logic        irq;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic        we;
    exp_t        e;
  } vec_t;

  exp_t sb_q[$];
  vec_t vt[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic exp_t mk(logic crd, logic [31:0] rd, logic cmis, logic m,
                              logic cirq, logic i);
    exp_t e;
    e.crd = crd; e.rd = rd; e.cmis = cmis; e.mis = m; e.cirq = cirq; e.irq = i;
    return e;
  endfunction

  function automatic void addv(logic [31:0] a, logic [31:0] d, logic [1:0] s,
                               logic we, logic crd, logic [31:0] rd,
                               logic cmis, logic m);
    vec_t v;
    v.addr = a; v.data = d; v.size = s; v.we = we;
    v.e = mk(crd, rd, cmis, m, 1'b0, 1'b0);
    vt.push_back(v);
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one access, push its expectation, compare mid-cycle, advance past edge
  task automatic step(string nm, logic [31:0] a, logic [31:0] d, logic [1:0] s,
                      logic we, exp_t e);
    exp_t cur;
    bus.mem_addr    = a;
    bus.mem_st_data = d;
    bus.mem_op_size = s;
    bus.mem_wr_en   = we;
    sb_q.push_back(e);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL %s: scoreboard empty got 1 expected 0", nm);
    end else begin
      cur = sb_q.pop_front();
      if (cur.crd)  check({nm, ".rd"},  bus.mem_rd_data, cur.rd);
      if (cur.cmis) check({nm, ".mis"}, {31'd0, mis}, {31'd0, cur.mis});
      if (cur.cirq) check({nm, ".irq"}, {31'd0, irq}, {31'd0, cur.irq});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rd(string nm, logic [31:0] a, logic [1:0] s, logic [31:0] exp,
                    logic cirq, logic i);
    step(nm, a, 32'd0, s, 1'b0, mk(1'b1, exp, 1'b0, 1'b0, cirq, i));
  endtask

  task automatic wr(string nm, logic [31:0] a, logic [31:0] d, logic cirq, logic i);
    step(nm, a, d, SW, 1'b1, mk(1'b0, 32'd0, 1'b0, 1'b0, cirq, i));
  endtask

  initial begin
    // vector table: addr, data, size, we, chk_rd, exp_rd, chk_mis, exp_mis
    addv(32'h10,        32'h1122_3344, SW, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0);
    addv(32'h11,        32'h0000_00AA, SB, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0);
    addv(32'h10,        32'h0,         SW, 1'b0, 1'b1, 32'h1122_AA44, 1'b1, 1'b0);
    addv(32'h13,        32'h0,         SB, 1'b0, 1'b1, 32'h0000_0011, 1'b0, 1'b0);
    addv(32'h12,        32'h0,         SH, 1'b0, 1'b1, 32'h0000_1122, 1'b0, 1'b0);
    addv(32'h11,        32'h0,         SB, 1'b0, 1'b1, 32'h0000_00AA, 1'b0, 1'b0);
    addv(32'h12,        32'h0000_5566, SH, 1'b1, 1'b1, 32'h0000_1122, 1'b0, 1'b0);
    addv(32'h10,        32'h0,         SW, 1'b0, 1'b1, 32'h5566_AA44, 1'b0, 1'b0);
    addv(32'h20,        32'h0BAD_F00D, SW, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0);
    addv(32'h20,        32'hDEAD_BEEF, SW, 1'b1, 1'b1, 32'h0BAD_F00D, 1'b0, 1'b0);
    addv(32'h20,        32'h0,         SW, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    addv(32'h22,        32'h0,         SH, 1'b0, 1'b1, 32'h0000_DEAD, 1'b0, 1'b0);
    addv(32'h20,        32'h0,         SH, 1'b0, 1'b1, 32'h0000_BEEF, 1'b0, 1'b0);
    addv(32'h21,        32'h0,         SB, 1'b0, 1'b1, 32'h0000_00BE, 1'b0, 1'b0);
    addv(B,             32'h0000_005A, SW, 1'b1, 1'b1, 32'h0,         1'b0, 1'b0);
    addv(B,             32'h0,         SW, 1'b0, 1'b1, 32'h0000_005A, 1'b0, 1'b0);
    addv(B + 32'h14,    32'h0,         SW, 1'b0, 1'b1, 32'h0,         1'b1, 1'b0);
    addv(32'h2000_0000, 32'h0000_1234, SW, 1'b1, 1'b1, 32'h0,         1'b0, 1'b0);
    addv(32'h2000_0000, 32'h0,         SW, 1'b0, 1'b1, 32'h0,         1'b1, 1'b0);
    addv(32'h2000_0001, 32'h0,         SW, 1'b0, 1'b1, 32'h0,         1'b1, 1'b0);
    addv(B + 32'h18,    32'h0,         SW, 1'b0, 1'b1, 32'h0,         1'b1, 1'b0);
    addv(B + 32'h18,    32'h0000_FFFF, SW, 1'b1, 1'b1, 32'h0,         1'b1, 1'b0);
    addv(B + 32'h18,    32'h0,         SW, 1'b0, 1'b1, 32'h0,         1'b1, 1'b0);
    addv(B + 32'h0C,    32'h0,         SW, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    addv(B + 32'h10,    32'h0,         SW, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    addv(32'h22,        32'h1234_5678, SW, 1'b1, 1'b1, 32'h0,         1'b1, 1'b0);
    addv(32'h20,        32'h0,         SW, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
    addv(B + 32'h14,    32'h0,         SW, 1'b0, 1'b1, 32'h0000_0001, 1'b1, 1'b1);
    addv(B + 32'h14,    32'h0000_0002, SW, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b1);
    addv(B + 32'h14,    32'h0000_0001, SW, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b1);
    addv(B + 32'h14,    32'h0,         SW, 1'b0, 1'b1, 32'h0,         1'b1, 1'b0);
    addv(B,             32'h0,         SH, 1'b0, 1'b1, 32'h0,         1'b1, 1'b0);
    addv(B,             32'h0,         SW, 1'b0, 1'b1, 32'h0000_005A, 1'b1, 1'b1);
    addv(B + 32'h14,    32'h0000_0001, SW, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b1);
    addv(32'h11,        32'h0,         SH, 1'b0, 1'b1, 32'h0,         1'b1, 1'b0);
    addv(32'h10,        32'h0,         SW, 1'b0, 1'b1, 32'h5566_AA44, 1'b1, 1'b1);
    addv(32'h13,        32'hFFFF_FFFF, SW, 1'b1, 1'b1, 32'h0,         1'b1, 1'b1);
    addv(32'h10,        32'h0,         SW, 1'b0, 1'b1, 32'h5566_AA44, 1'b1, 1'b1);
    addv(32'h12,        32'h0000_7788, SH, 1'b1, 1'b1, 32'h0000_5566, 1'b1, 1'b1);
    addv(32'h10,        32'h0,         SW, 1'b0, 1'b1, 32'h7788_AA44, 1'b1, 1'b1);
    addv(B + 32'h14,    32'h0000_0001, SW, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b1);
    addv(32'h10,        32'h0,         SW, 1'b0, 1'b1, 32'h7788_AA44, 1'b1, 1'b0);

    // reset, leaving the first post-reset cycle current
    rst             = 1'b1;
    bus.mem_addr    = 32'h0;
    bus.mem_st_data = 32'h0;
    bus.mem_op_size = SW;
    bus.mem_wr_en   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst.gpio", gpio, 32'h0);
    step("rst.mtime", B + 32'h04, 32'h0, SW, 1'b0,
         mk(1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0));
    rd("rst.cmphi", B + 32'h10, SW, 32'hFFFF_FFFF, 1'b1, 1'b0);

    foreach (vt[i]) begin
      step($sformatf("vec%0d", i), vt[i].addr, vt[i].data, vt[i].size, vt[i].we, vt[i].e);
    end
    check("gpio_out", gpio, 32'h0000_005A);

    // timer compare / interrupt
    wr("t.mtlo0", B + 32'h04, 32'h0,  1'b1, 1'b0);
    wr("t.mthi0", B + 32'h08, 32'h0,  1'b1, 1'b0);
    wr("t.cmphi", B + 32'h10, 32'h0,  1'b1, 1'b0);
    wr("t.cmplo", B + 32'h0C, 32'd100, 1'b1, 1'b0);
    wr("t.mt90",  B + 32'h04, 32'd90, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) begin
      rd($sformatf("t.mt%0d", 90 + i), B + 32'h04, SW, 32'(90 + i), 1'b1, (90 + i) >= 100);
    end
    rd("t.status", B + 32'h14, SW, 32'h0000_0002, 1'b1, 1'b1);
    step("t.mtclr", B + 32'h04, 32'h0, SW, 1'b1, mk(1'b1, 32'd106, 1'b0, 1'b0, 1'b1, 1'b1));
    rd("t.mtlo_after", B + 32'h04, SW, 32'h0, 1'b1, 1'b0);
    rd("t.mthi_after", B + 32'h08, SW, 32'h0, 1'b1, 1'b0);

    // timer wrap
    wr("w.hi", B + 32'h08, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wr("w.lo", B + 32'h04, 32'hFFFF_FFFE, 1'b1, 1'b1);
    rd("w.lo1", B + 32'h04, SW, 32'hFFFF_FFFE, 1'b1, 1'b1);
    rd("w.hi2", B + 32'h08, SW, 32'hFFFF_FFFF, 1'b1, 1'b1);
    rd("w.lo3", B + 32'h04, SW, 32'h0, 1'b1, 1'b0);
    rd("w.hi4", B + 32'h08, SW, 32'h0, 1'b1, 1'b0);

    // mid-run reset with a store in the reset cycle
    rd("r.misrd", 32'h11, SH, 32'h0, 1'b0, 1'b0);
    check("r.gpio_pre", gpio, 32'h0000_005A);
    rst = 1'b1;
    step("r.rststore", 32'h10, 32'hFFFF_FFFF, SW, 1'b1,
         mk(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0));
    rst = 1'b0;
    check("r.gpio", gpio, 32'h0);
    step("r.mtime", B + 32'h04, 32'h0, SW, 1'b0, mk(1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0));
    rd("r.ram10", 32'h10, SW, 32'h7788_AA44, 1'b1, 1'b0);
    rd("r.ram20", 32'h20, SW, 32'hDEAD_BEEF, 1'b0, 1'b0);
    rd("r.cmplo", B + 32'h0C, SW, 32'hFFFF_FFFF, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
